// File: rtl/bram_arbiter.sv
// Round-robin two-port front end for a single-port block RAM with 2-cycle registered reads.
// The RAM (address and output registers cleared by aclr) is modelled inline.
module bram_arbiter #(
  parameter int unsigned ADDR_          = 8,
  parameter int unsigned DATA_          = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [ADDR_-1:0] a_addr,
  input  logic [DATA_-1:0] a_din,
  output logic             a_rdy,
  output logic             a_rvalid,
  output logic [DATA_-1:0] a_rdata,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [ADDR_-1:0] b_addr,
  input  logic [DATA_-1:0] b_din,
  output logic             b_rdy,
  output logic             b_rvalid,
  output logic [DATA_-1:0] b_rdata,
  output logic             init_done
);

  localparam int unsigned Words = 2 ** ADDR_;
  localparam logic [ADDR_-1:0] LastAddr = {ADDR_{1'b1}};

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e           state_q, state_d;
  logic [ADDR_-1:0] clr_cnt_q, clr_cnt_d;
  logic             last_b_q, last_b_d;  // 1 = port B was granted most recently
  logic             win_a, win_b;

  logic             ram_we;
  logic [ADDR_-1:0] ram_addr;
  logic [DATA_-1:0] ram_din;

  // Read tracking: bit 0 = accepted last cycle, bit 1 = response due this cycle
  logic [1:0]       rd_vld_q;
  logic [1:0]       rd_port_q;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    last_b_d  = last_b_q;
    win_a     = 1'b0;
    win_b     = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = a_addr;
    ram_din   = a_din;
    unique case (state_q)
      StClear: begin
        ram_we    = 1'b1;
        ram_addr  = clr_cnt_q;
        ram_din   = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LastAddr) begin
          state_d   = StRun;
          clr_cnt_d = '0;
        end
      end
      StRun: begin
        win_a = a_req & (~b_req | last_b_q);
        win_b = b_req & ~win_a;
        if (win_a) begin
          ram_we   = a_we;
          ram_addr = a_addr;
          ram_din  = a_din;
          last_b_d = 1'b0;
        end else if (win_b) begin
          ram_we   = b_we;
          ram_addr = b_addr;
          ram_din  = b_din;
          last_b_d = 1'b1;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q   <= CLEAR_ON_RESET ? StClear : StRun;
      clr_cnt_q <= '0;
      last_b_q  <= 1'b1;
      rd_vld_q  <= 2'b00;
      rd_port_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      last_b_q  <= last_b_d;
      rd_vld_q  <= {rd_vld_q[0], (win_a & ~a_we) | (win_b & ~b_we)};
      rd_port_q <= {rd_port_q[0], win_b};
    end
  end

  assign a_rdy     = win_a;
  assign b_rdy     = win_b;
  assign a_rvalid  = rd_vld_q[1] & ~rd_port_q[1];
  assign b_rvalid  = rd_vld_q[1] & rd_port_q[1];
  assign init_done = (state_q == StRun);

  // Block RAM: registered address, registered output, array itself not reset.
  logic [DATA_-1:0] mem [Words];
  logic [ADDR_-1:0] addr_q;
  logic [DATA_-1:0] q_q;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
  end

  // The array read sees writes committed on earlier edges, so write-then-read returns new data.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      addr_q <= '0;
      q_q    <= '0;
    end else begin
      addr_q <= ram_addr;
      q_q    <= mem[addr_q];
    end
  end

  assign a_rdata = q_q;
  assign b_rdata = q_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: behavioural model + per-cycle compare, directed scenarios, random traffic.
// A second instance exercises CLEAR_ON_RESET=0.
module tb_bram_arbiter;
  localparam int NW = 16;

  logic       clk = 1'b0;
  logic       aclr_n = 1'b0;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [3:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_din = '0, b_din = '0;
  logic       a_rdy, a_rvalid, b_rdy, b_rvalid, init_done;
  logic [7:0] a_rdata, b_rdata;

  logic       c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [3:0] c_addr = '0, d_addr = '0;
  logic [7:0] c_din = '0, d_din = '0;
  logic       c_rdy, c_rvalid, d_rdy, d_rvalid, c_init;
  logic [7:0] c_rdata, d_rdata;

  bram_arbiter #(.ADDR_(4), .DATA_(8), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .aclr_n(aclr_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_rdy(a_rdy), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_rdy(b_rdy), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .init_done(init_done)
  );

  bram_arbiter #(.ADDR_(4), .DATA_(8), .CLEAR_ON_RESET(1'b0)) dut_nc (
    .clk(clk), .aclr_n(aclr_n),
    .a_req(c_req), .a_we(c_we), .a_addr(c_addr), .a_din(c_din),
    .a_rdy(c_rdy), .a_rvalid(c_rvalid), .a_rdata(c_rdata),
    .b_req(d_req), .b_we(d_we), .b_addr(d_addr), .b_din(d_din),
    .b_rdy(d_rdy), .b_rvalid(d_rvalid), .b_rdata(d_rdata),
    .init_done(c_init)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: memory contents, clear countdown, last winner, outstanding responses.
  typedef struct {
    int         due;
    bit         port_b;
    logic [7:0] data;
  } rsp_t;

  rsp_t       rq[$];
  logic [7:0] mem_m [NW];
  int         clear_left = NW;
  bit         last_b = 1'b1;
  int         cyc = 0;
  bit         exp_a = 1'b0, exp_b = 1'b0;
  int         a_rv_cnt = 0;

  always @(posedge clk or negedge aclr_n) begin : model
    logic       we;
    logic [3:0] ad;
    logic [7:0] dn;
    if (!aclr_n) begin
      clear_left = NW;
      last_b     = 1'b1;
      exp_a      = 1'b0;
      exp_b      = 1'b0;
      rq.delete();
    end else begin
      if (clear_left > 0) begin
        mem_m[NW - clear_left] = 8'h00;
        clear_left--;
      end else if (exp_a || exp_b) begin
        we = exp_b ? b_we : a_we;
        ad = exp_b ? b_addr : a_addr;
        dn = exp_b ? b_din : a_din;
        last_b = exp_b;
        if (we) mem_m[ad] = dn;
        else rq.push_back('{due: cyc + 2, port_b: exp_b, data: mem_m[ad]});
      end
      cyc++;
    end
  end

  always @(negedge clk) begin : compare
    bit         run, rva, rvb;
    logic [7:0] rd;
    if (!aclr_n) begin
      exp_a = 1'b0;
      exp_b = 1'b0;
      check("rst_a_rdy", a_rdy, 0);
      check("rst_b_rdy", b_rdy, 0);
      check("rst_a_rvalid", a_rvalid, 0);
      check("rst_b_rvalid", b_rvalid, 0);
      check("rst_rdata", a_rdata, 0);
      check("rst_init_done", init_done, 0);
    end else begin
      run   = (clear_left == 0);
      exp_a = run && a_req && (!b_req || last_b);
      exp_b = run && b_req && !exp_a;
      check("init_done", init_done, 32'(run));
      check("a_rdy", a_rdy, 32'(exp_a));
      check("b_rdy", b_rdy, 32'(exp_b));
      rva = 1'b0;
      rvb = 1'b0;
      rd  = 8'h00;
      for (int i = rq.size() - 1; i >= 0; i--) begin
        if (rq[i].due <= cyc) begin
          if (rq[i].due == cyc) begin
            if (rq[i].port_b) rvb = 1'b1;
            else rva = 1'b1;
            rd = rq[i].data;
          end
          rq.delete(i);
        end
      end
      check("a_rvalid", a_rvalid, 32'(rva));
      check("b_rvalid", b_rvalid, 32'(rvb));
      if (rva) check("a_rdata", a_rdata, 32'(rd));
      if (rvb) check("b_rdata", b_rdata, 32'(rd));
      if (a_rvalid) a_rv_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit port_b, input logic [3:0] ad, input logic [7:0] d);
    bit got;
    got = 1'b0;
    tick();
    if (port_b) begin b_req = 1; b_we = 1; b_addr = ad; b_din = d; end
    else begin a_req = 1; a_we = 1; a_addr = ad; a_din = d; end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = port_b ? b_rdy : a_rdy;
      if (!got) tick();
    end
    check("wr_accept", 32'(got), 1);
    tick();
    a_req = 0;
    b_req = 0;
  endtask

  // Counts cycles with init_done low after release; a_early counts rdy seen during that time.
  task automatic wait_init(output int cnt, output int a_early, output int rv);
    cnt = 0; a_early = 0; rv = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_rvalid) rv++;
      if (init_done) break;
      cnt++;
      if (a_rdy) a_early++;
    end
  endtask

  initial begin : stim
    int         cnt, early, rv, rv0, ra, rb, bad, first_rv;
    logic [5:0] gseq, bseq;
    bit         ga, gb;

    aclr_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_init_done", init_done, 0);
    check("reset_nc_init_done", c_init, 1);
    check("reset_nc_rdy", c_rdy, 0);

    // Release: dut holds a read of addr 0 through CLEAR; dut_nc is served at once.
    aclr_n = 1;
    a_req = 1; a_we = 0; a_addr = 0;
    c_req = 1; c_we = 1; c_addr = 5; c_din = 8'h3C;
    fork
      begin
        wait_init(cnt, early, rv);
        check("clear_cycles", cnt, 16);
        check("rdy_during_clear", early, 0);
        check("first_run_rdy", a_rdy, 1);
      end
      begin
        @(negedge clk);
        check("nc_first_rdy", c_rdy, 1);
        check("nc_init_done", c_init, 1);
        tick();
        c_we = 0;
        @(negedge clk);
        check("nc_read_rdy", c_rdy, 1);
        tick();
        c_req = 0;
        @(negedge clk);
        check("nc_rvalid_t1", c_rvalid, 0);
        @(negedge clk);
        check("nc_rvalid_t2", c_rvalid, 1);
        check("nc_rdata", c_rdata, 8'h3C);
      end
    join

    // Read back every address (addr 0 accepted above).
    rv0 = a_rv_cnt - 0;
    for (int k = 1; k < NW; k++) begin
      tick();
      a_addr = 4'(k);
      @(negedge clk);
    end
    tick();
    a_req = 0;
    repeat (4) @(negedge clk);
    check("readback_count", a_rv_cnt - rv0, 16);

    // Write 0x5A to 3, read it back the next cycle.
    tick();
    a_req = 1; a_we = 1; a_addr = 3; a_din = 8'h5A;
    @(negedge clk);
    check("wr5a_rdy", a_rdy, 1);
    tick();
    a_we = 0;
    @(negedge clk);
    check("rd5a_rdy", a_rdy, 1);
    tick();
    a_req = 0;
    @(negedge clk);
    check("rd5a_rvalid_t1", a_rvalid, 0);
    @(negedge clk);
    check("rd5a_rvalid_t2", a_rvalid, 1);
    check("rd5a_rdata", a_rdata, 8'h5A);
    check("rd5a_b_rvalid", b_rvalid, 0);
    @(negedge clk);
    check("rd5a_rvalid_t3", a_rvalid, 0);

    // Contention: both ports read every cycle for six cycles.
    wr(1'b0, 4'd1, 8'h11);
    wr(1'b1, 4'd2, 8'h22);
    a_req = 1; a_we = 0; a_addr = 1;
    b_req = 1; b_we = 0; b_addr = 2;
    gseq = '0; bseq = '0; ra = 0; rb = 0; bad = 0; first_rv = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i < 6) begin
        gseq = {gseq[4:0], a_rdy};
        bseq = {bseq[4:0], b_rdy};
      end
      if ((a_rvalid || b_rvalid) && first_rv < 0) first_rv = i;
      if (a_rvalid) begin ra++; if (a_rdata != 8'h11) bad++; end
      if (b_rvalid) begin rb++; if (b_rdata != 8'h22) bad++; end
      tick();
      if (i == 5) begin a_req = 0; b_req = 0; end
    end
    check("rr_grants_a", gseq, 6'b101010);
    check("rr_grants_b", bseq, 6'b010101);
    check("rr_resp_a", ra, 3);
    check("rr_resp_b", rb, 3);
    check("rr_resp_data", bad, 0);
    check("rr_first_resp", first_rv, 2);

    // B writes 0x7E to 9, A reads 9 the following cycle.
    tick();
    b_req = 1; b_we = 1; b_addr = 9; b_din = 8'h7E;
    @(negedge clk);
    check("mix_b_rdy", b_rdy, 1);
    tick();
    b_req = 0;
    a_req = 1; a_we = 0; a_addr = 9;
    @(negedge clk);
    check("mix_a_rdy", a_rdy, 1);
    tick();
    a_req = 0;
    @(negedge clk);
    check("mix_rvalid_t2", a_rvalid, 0);
    @(negedge clk);
    check("mix_rvalid_t3", a_rvalid, 1);
    check("mix_rdata", a_rdata, 8'h7E);

    // Random traffic; each requester holds its request until granted.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      ga = a_rdy;
      gb = b_rdy;
      tick();
      if (!a_req || ga) begin
        a_req = ($urandom_range(0, 3) != 0);
        a_we = 1'($urandom_range(0, 1));
        a_addr = 4'($urandom_range(0, NW - 1));
        a_din = 8'($urandom);
      end
      if (!b_req || gb) begin
        b_req = ($urandom_range(0, 3) != 0);
        b_we = 1'($urandom_range(0, 1));
        b_addr = 4'($urandom_range(0, NW - 1));
        b_din = 8'($urandom);
      end
    end
    @(negedge clk);
    tick();
    a_req = 0;
    b_req = 0;
    repeat (4) tick();

    // Reset while a read is in flight.
    a_req = 1; a_we = 0; a_addr = 4;
    @(negedge clk);
    check("rst_mid_rdy", a_rdy, 1);
    tick();
    a_req = 0;
    aclr_n = 0;
    rv = 0;
    repeat (3) begin
      @(negedge clk);
      if (a_rvalid) rv++;
    end
    tick();
    aclr_n = 1;
    @(negedge clk);
    check("rst_mid_init_drop", init_done, 0);
    if (a_rvalid) rv++;
    wait_init(cnt, early, ra);
    check("rst_mid_no_rvalid", rv + ra, 0);
    check("rst_mid_clear_cycles", cnt + 1, 16);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for one single-port block RAM (`brams` instance held inside this block).
- Gives ports A and B (e.g. fetch and load/store) a req/rdy handshake and tracks the RAM's 2-cycle registered read latency so each read response returns on the port that issued it.
- Optional post-reset sweep clears every RAM word to zero before any requester is served.

Parameters:
- ADDR_, 8, address width; the RAM has 2**ADDR_ words.
- DATA_, 8, data width.
- CLEAR_ON_RESET, 1, 1 = zero the whole RAM after reset; 0 = serve requests immediately.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- aclr_n  in  1  asynchronous active-low reset; also drives the RAM's aclr (inverted).
- a_req  in  1  port A request; A holds a_req, a_we, a_addr and a_din stable until a_rdy.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  ADDR_  port A word address.
- a_din  in  DATA_  port A write data.
- a_rdy  out  1  port A request accepted this cycle.
- a_rvalid  out  1  port A read data valid.
- a_rdata  out  DATA_  port A read data.
- b_req, b_we, b_addr, b_din, b_rdy, b_rvalid, b_rdata: same as port A, for port B.
- init_done  out  1  high once the RAM is usable.

Behaviour:
- Reset (aclr_n low, asynchronous):
  - FSM goes to CLEAR if CLEAR_ON_RESET=1, else RUN.
  - Clear counter = 0; last-grant pointer = B.
  - Read pipeline valid bits = 0.
  - a_rvalid = b_rvalid = 0, a_rdy = b_rdy = 0.
  - a_rdata = b_rdata = 0, because the RAM output register is cleared.
  - init_done = 0 if CLEAR_ON_RESET=1, else 1.
- FSM CLEAR:
  - RAM we=1, addr=counter, din=0; counter increments each cycle.
  - a_rdy = b_rdy = 0 regardless of req.
  - When counter = 2**ADDR_-1, that write completes and the FSM enters RUN on the next edge.
  - CLEAR lasts exactly 2**ADDR_ cycles.
- FSM RUN:
  - init_done = 1.
  - Grant is combinational in the same cycle:
    - only one req high: that port wins;
    - both high: the port that is not last-grant wins;
    - neither high: RAM we=0, no grant.
  - x_rdy = x_req & win_x; at most one rdy is high per cycle.
  - On each grant, last-grant is updated to the winner.
- Mux: the winner's addr, din and we drive the RAM in the same cycle. The RAM registers the address on the edge closing the accept cycle T.
- Write: committed at the end of cycle T. No response is produced.
- Read:
  - Accepted in cycle T; x_rvalid is high for exactly cycle T+2.
  - x_rdata = RAM q in that cycle.
  - Fixed 2-cycle latency, fully pipelined: one accepted read per cycle is allowed, any port mix.
- Read-response tracking: a 2-stage shift register of {valid, port_id}. Stage 2 drives the rvalid outputs. x_rdata is the shared RAM q routed to both ports, meaningful only while x_rvalid is high.
- Read-during-write / write-then-read: a read of address X accepted in the cycle after a write to X returns the new data. The RAM is configured NEW_DATA.
- Starvation bound: with both ports continuously requesting, grants alternate A,B,A,B. Each port waits at most 1 cycle.
- x_req while in CLEAR: held pending, not dropped. It is granted from the first RUN cycle.
- Reset mid-operation:
  - in-flight reads are discarded, with no rvalid after reset;
  - pending writes not yet accepted are lost;
  - CLEAR restarts from address 0.
- No handshake backpressure on responses: requesters must always accept an rvalid.

Test Plan:
- Reset clear: ADDR_=4, CLEAR_ON_RESET=1, release aclr_n. Expect init_done low for 16 cycles, then high. Any a_req held meanwhile sees a_rdy=0 until cycle 17. Reading all 16 addresses afterwards returns 0x00.
- Single-port write/read: A writes 0x5A to addr 3, then reads addr 3 the next cycle. Expect a_rdy both cycles; a_rvalid exactly 2 cycles after the read accept, with a_rdata=0x5A; b_rvalid stays 0.
- Contention: both ports request reads every cycle for 6 cycles, addr A=1, B=2, memory preloaded [1]=0x11, [2]=0x22. Expect grants A,B,A,B,A,B; responses 0x11 (A), 0x22 (B) alternating, starting 2 cycles after the first grant.
- Mixed pipeline: B writes 0x7E to addr 9 in cycle T; A reads addr 9 in T+1. Expect a_rvalid at T+3 with a_rdata=0x7E.
- Reset mid-read: A read accepted at T, aclr_n asserted at T+1. Expect a_rvalid never asserted; after release, CLEAR reruns and init_done drops.
- CLEAR_ON_RESET=0: after reset init_done=1 immediately; a_req in the first cycle is granted the same cycle.
